// File: rtl/note_code_player.sv
// Note-code playback: latches a 4-bit note code and a beat count, then drives a
// one-hot key/LED pattern for that many beats followed by a silent gap.
module note_code_player #(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000,
  parameter int unsigned DUR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       note_code,
  input  logic [DUR_W-1:0] duration,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stop,
  output logic [7:0]       key_led,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam int unsigned GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic              HAS_GAP   = (GAP_TICKS != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [7:0]        key_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              done_d, err_d;
  logic              accept_c;

  // Legal notes map to a single LED; rests and illegal codes stay dark.
  function automatic logic [7:0] decode(input logic [3:0] code);
    logic [7:0] pat;
    pat = 8'h00;
    case (code)
      4'd1: pat = 8'h01;
      4'd2: pat = 8'h02;
      4'd3: pat = 8'h04;
      4'd4: pat = 8'h08;
      4'd5: pat = 8'h10;
      4'd6: pat = 8'h20;
      4'd7: pat = 8'h40;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  function automatic logic illegal(input logic [3:0] code);
    return (code == 4'd0) || ((code >= 4'd8) && (code <= 4'd14));
  endfunction

  assign in_ready = (state_q == S_IDLE) && !stop;
  assign busy     = (state_q != S_IDLE);
  assign accept_c = in_valid && in_ready;

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    key_d   = key_led;
    tick_d  = tick_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          dur_d  = duration;
          err_d  = illegal(note_code);
          tick_d = '0;
          beat_d = '0;
          gap_d  = '0;
          if (duration == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PLAY;
            key_d   = decode(note_code);
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          key_d   = 8'h00;
          tick_d  = '0;
          beat_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (beat_q == dur_q - DUR_W'(1)) begin
            key_d  = 8'h00;
            beat_d = '0;
            if (HAS_GAP) begin
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + DUR_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        key_d   = 8'h00;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_led <= 8'h00;
      tick_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      dur_q   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      key_led <= key_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      dur_q   <= dur_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_note_code_player.sv
// Directed bench for note_code_player with TICKS_PER_BEAT=4, GAP_TICKS=2.
module tb_note_code_player;

  localparam int unsigned TPB = 4;
  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] note_code = 4'd0;
  logic [7:0] duration = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       stop = 1'b0;
  logic [7:0] key_led;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  note_code_player #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .DUR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .note_code(note_code), .duration(duration),
    .in_valid(in_valid), .in_ready(in_ready), .stop(stop), .key_led(key_led),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [7:0] dur;
    logic [7:0] led;
    logic       e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'd3,  8'd2,   8'h04, 1'b0};
    vecs[1] = '{4'd1,  8'd1,   8'h01, 1'b0};
    vecs[2] = '{4'd7,  8'd1,   8'h40, 1'b0};
    vecs[3] = '{4'd15, 8'd3,   8'h00, 1'b0};
    vecs[4] = '{4'd9,  8'd1,   8'h00, 1'b1};
    vecs[5] = '{4'd5,  8'd0,   8'h00, 1'b0};
    vecs[6] = '{4'd0,  8'd1,   8'h00, 1'b1};
    vecs[7] = '{4'd14, 8'd0,   8'h00, 1'b1};
    vecs[8] = '{4'd6,  8'd255, 8'h20, 1'b0};
    vecs[9] = '{4'd4,  8'd1,   8'h08, 1'b0};

    // Reset values while rst_n is low.
    #3;
    chk("rst_key_led", 32'(key_led), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #9 rst_n = 1'b1;
    step();

    // Table: each entry offered in the cycle the previous one reports done.
    for (int i = 0; i < 10; i++) begin
      int total;
      total = int'(vecs[i].dur) * int'(TPB);
      chk("pre_in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      note_code = vecs[i].code;
      duration  = vecs[i].dur;
      step();
      in_valid  = 1'b0;
      note_code = 4'd2;
      duration  = 8'd7;
      chk("err_pulse", 32'(err), 32'(vecs[i].e));
      if (vecs[i].dur == 8'd0) begin
        chk("d0_done", 32'(done), 32'd1);
        chk("d0_busy", 32'(busy), 32'd0);
        chk("d0_led", 32'(key_led), 32'h00);
        step();
        chk("d0_done_clear", 32'(done), 32'd0);
        chk("d0_err_clear", 32'(err), 32'd0);
      end else begin
        for (int k = 0; k < total; k++) begin
          chk("play_led", 32'(key_led), 32'(vecs[i].led));
          chk("play_busy", 32'(busy), 32'd1);
          if (k == 0) chk("play_done_low", 32'(done), 32'd0);
          if (k == 1) chk("err_one_cycle", 32'(err), 32'd0);
          step();
        end
        for (int g = 0; g < int'(GAP); g++) begin
          chk("gap_led", 32'(key_led), 32'h00);
          chk("gap_busy", 32'(busy), 32'd1);
          chk("gap_done_low", 32'(done), 32'd0);
          step();
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd1);
      end
    end
    step();
    chk("idle_done_clear", 32'(done), 32'd0);

    // stop on the 3rd PLAY cycle of code 2, D=4.
    in_valid = 1'b1; note_code = 4'd2; duration = 8'd4;
    step();
    in_valid = 1'b0;
    chk("stop_play1_led", 32'(key_led), 32'h02);
    step();
    step();
    chk("stop_play3_led", 32'(key_led), 32'h02);
    stop = 1'b1;
    step();
    chk("stop_led", 32'(key_led), 32'h00);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ready_held", 32'(in_ready), 32'd0);
    chk("stop_no_done", 32'(done), 32'd0);
    stop = 1'b0;
    #1;
    chk("stop_ready_rel", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("stop_no_late_done", 32'(done), 32'd0);
    end

    // stop and in_valid together in IDLE: nothing accepted.
    stop = 1'b1; in_valid = 1'b1; note_code = 4'd3; duration = 8'd1;
    step();
    chk("stop_wins_busy", 32'(busy), 32'd0);
    chk("stop_wins_led", 32'(key_led), 32'h00);
    stop = 1'b0; in_valid = 1'b0;
    step();
    chk("stop_wins_no_done", 32'(done), 32'd0);

    // Async reset between edges mid-PLAY.
    in_valid = 1'b1; note_code = 4'd5; duration = 8'd2;
    step();
    in_valid = 1'b0;
    step();
    chk("arst_pre_led", 32'(key_led), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(key_led), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/note_code_player.md
Name: note_code_player

Overview:
- Playback-side counterpart of the keyboard note encoder. It accepts 4-bit note codes (1..7 = notes, 15 = none/rest) with a duration in beats over a valid/ready handshake.
- For each accepted note it drives the matching one-hot 8-bit key/LED pattern for the requested number of beats, then a short silent gap.
- It sits between the song-memory sequencer (auto-play / learning mode) and the key-LED and buzzer-select logic.

Parameters:
- TICKS_PER_BEAT, 25_000_000, clk cycles per beat; must be ≥1.
- GAP_TICKS, 2_500_000, silent clk cycles inserted after each note; 0 means no gap.
- DUR_W, 8, width of the duration field.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- note_code  input  4  note to play; 1..7 = note, 15 = rest, anything else is illegal.
- duration  input  DUR_W  note length in beats.
- in_valid  input  1  note_code/duration valid.
- in_ready  output  1  block can accept a note.
- stop  input  1  synchronous abort of the current note.
- key_led  output  8  one-hot pattern; bit n-1 is set for code n (1..7); bit 7 is always 0.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when a note (including its gap) finishes normally.
- err  output  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- Clock and reset: single clock domain. rst_n low asynchronously forces state IDLE and clears key_led, done, err and all counters.
- Reset values: in_ready=1, busy=0, key_led=8'h00, done=0, err=0.
- States: IDLE, PLAY, GAP.
  - in_ready = (state==IDLE) && !stop, combinational.
  - busy = (state!=IDLE).
- Accept: a handshake occurs on a rising edge with in_valid && in_ready. The block latches note_code and duration at that edge.
- Duration 0:
  - No PLAY and no GAP. State stays IDLE and key_led stays 0.
  - done pulses in the cycle after the accepting edge.
- Duration D ≥ 1:
  - State → PLAY at the accepting edge.
  - key_led is registered and takes the decoded pattern in the cycle after that edge.
  - It holds for exactly D*TICKS_PER_BEAT cycles.
- Decode:
  - Code n in 1..7 → key_led = 1<<(n-1).
  - Code 15 → 8'h00 (rest; timing is identical to a note).
  - Codes 0 and 8..14 → treated as rest, and err pulses for one cycle after the accepting edge.
- Counters:
  - tick counter runs 0..TICKS_PER_BEAT-1 and wraps.
  - beat counter increments on each tick wrap.
  - PLAY ends on the wrap where beat == D-1.
  - Counter widths must hold TICKS_PER_BEAT-1 and 2^DUR_W-1 without overflow. Maximum D (all ones) must play the full 2^DUR_W-1 beats.
- PLAY → GAP: key_led = 0 and the counters are cleared. GAP lasts GAP_TICKS cycles.
- GAP_TICKS = 0: PLAY goes directly to IDLE.
- GAP → IDLE: done is high for the first IDLE cycle. in_ready is high in that same cycle, so back-to-back notes are allowed. Accept-to-next-ready period is D*TICKS_PER_BEAT + GAP_TICKS cycles.
- stop:
  - Sampled every edge. In PLAY or GAP it forces IDLE at the next edge and clears key_led and the counters.
  - It does not pulse done.
  - While stop is high no handshake occurs, since in_ready is 0.
- Simultaneous stop and in_valid in IDLE: stop wins and nothing is accepted.
- While busy, in_valid is ignored and note_code/duration may change freely. The latched copies are used.
- rst_n asserted mid-note: immediate return to reset values; no done pulse.

Test Plan (TICKS_PER_BEAT=4, GAP_TICKS=2, DUR_W=8):
- Reset release, then code 3 with D=2 → in the cycle after the accept, key_led=8'h04 for exactly 8 cycles. Then 8'h00 for 2 gap cycles, then done=1 for 1 cycle with in_ready=1. busy is high for 10 cycles.
- Back-to-back handshakes: code 1 D=1, then code 7 D=1, with in_valid held → key_led is 8'h01 (4 cycles), 0 (2 cycles), 8'h80… must not appear. Required: 8'h40 (4 cycles), 0 (2 cycles). Two done pulses spaced 6 cycles apart.
- Code 15 D=3 → key_led=0 throughout, busy for 14 cycles, done pulses, err stays 0. Code 9 D=1 → err pulses once, key_led=0, done after 6 cycles.
- D=0 with code 5 → busy never rises, key_led stays 0, done pulses in the next cycle.
- stop asserted on the 3rd PLAY cycle of code 2 D=4 → key_led=0 and busy=0 in the next cycle. No done pulse. in_ready=1 once stop is low.
- rst_n pulled low asynchronously mid-PLAY (between clock edges) → key_led=0, busy=0 and in_ready=1 immediately. No done pulse after release.
